// File: rtl/hello_uart_soc.sv
// hello_uart_soc: sends a fixed banner on UART_out after reset, then echoes
// every correctly framed byte received on UART_in (8N1, single-byte buffer).
module hello_uart_soc #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MSG_LEN = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic UART_in,
  output logic UART_out
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(MSG_LEN);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [103:0] MSG = {8'h0A, 8'h0D, "dlroW olleH"};
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_t;
  logic rst_ok_q, rx_s1_q, rx_s2_q;
  rx_t rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_sh_q;
  logic rx_done;
  tx_t tx_st_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_sh_q;
  logic tx_q;
  logic [IW-1:0] idx_q;
  logic pend_q, full_q;
  logic [7:0] buf_q;
  logic [7:0] rom_byte;
  assign rom_byte = MSG[{idx_q, 3'b000} +: 8];
  assign rx_done = rx_st_q == R_STOP && rx_cnt_q == LAST && rx_s2_q;
  assign UART_out = tx_q;
  // rst_ok_q delays functional release by one clock; the RX synchroniser idles high
  always_ff @(posedge clk or negedge rst)
    if (!rst) {rst_ok_q, rx_s1_q, rx_s2_q} <= 3'b011;
    else {rst_ok_q, rx_s1_q, rx_s2_q} <= {1'b1, UART_in, rx_s1_q};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_st_q <= R_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
    end else if (rst_ok_q) begin
      rx_cnt_q <= rx_cnt_q + 1'b1;
      case (rx_st_q)
        R_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_s2_q) rx_st_q <= R_START;
        end
        R_START: if (rx_cnt_q == HALF) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_st_q <= rx_s2_q ? R_IDLE : R_DATA;
        end
        R_DATA: if (rx_cnt_q == LAST) begin
          rx_cnt_q <= '0;
          rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_st_q <= R_STOP;
        end
        R_STOP: if (rx_cnt_q == LAST) rx_st_q <= rx_s2_q ? R_IDLE : R_WAIT;
        R_WAIT: if (rx_s2_q) rx_st_q <= R_IDLE;
        default: rx_st_q <= R_IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_st_q <= T_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_q <= 1'b1;
      idx_q <= '0;
      pend_q <= 1'b1;
      full_q <= 1'b0;
      buf_q <= '0;
    end else if (rst_ok_q) begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
      case (tx_st_q)
        T_IDLE: begin
          tx_cnt_q <= '0;
          if (pend_q || full_q) begin
            tx_st_q <= T_START;
            tx_q <= 1'b0;
            tx_sh_q <= pend_q ? rom_byte : buf_q;
          end
          if (pend_q) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == IW'(MSG_LEN - 1)) pend_q <= 1'b0;
          end else if (full_q) full_q <= 1'b0;
        end
        T_START: if (tx_cnt_q == LAST) begin
          tx_cnt_q <= '0;
          tx_bit_q <= '0;
          tx_q <= tx_sh_q[0];
          tx_st_q <= T_DATA;
        end
        // ones shift in behind the data so the last shift presents the stop level
        T_DATA: if (tx_cnt_q == LAST) begin
          tx_cnt_q <= '0;
          tx_bit_q <= tx_bit_q + 1'b1;
          tx_sh_q <= {1'b1, tx_sh_q[7:1]};
          tx_q <= tx_sh_q[1];
          if (tx_bit_q == 3'd7) tx_st_q <= T_STOP;
        end
        T_STOP: if (tx_cnt_q == LAST) tx_st_q <= T_IDLE;
        default: tx_st_q <= T_IDLE;
      endcase
      if (rx_done) begin
        buf_q <= rx_sh_q;
        full_q <= 1'b1;
      end
    end
endmodule

// File: tb/tb_hello_uart_soc.sv
// tb_hello_uart_soc: directed bench with a byte scoreboard fed by the stimulus
// and drained by a UART_out frame decoder.
module tb_hello_uart_soc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic UART_in = 1'b1;
  logic UART_out;
  int checks = 0;
  int failures = 0;
  int frames = 0;
  logic [7:0] exp_q[$];
  logic [103:0] banner = {8'h0A, 8'h0D, 8'h64, 8'h6C, 8'h72, 8'h6F, 8'h57, 8'h20, 8'h6F, 8'h6C, 8'h6C, 8'h65, 8'h48};
  hello_uart_soc #(.CLKS_PER_BIT(4), .MSG_LEN(13)) dut (
    .clk(clk), .rst(rst), .UART_in(UART_in), .UART_out(UART_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    UART_in = 1'b0;
    cyc(4);
    for (int i = 0; i < 8; i++) begin
      UART_in = b[i];
      cyc(4);
    end
    UART_in = stop;
    cyc(4);
    UART_in = 1'b1;
  endtask
  task automatic push_banner();
    exp_q.delete();
    for (int i = 0; i < 13; i++) exp_q.push_back(banner[i*8 +: 8]);
  endtask
  task automatic wait_empty(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      cyc(1);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask
  // frame decoder: sample mid-bit on negedges, 4 clocks per bit
  int mon_t = 0;
  bit mon_busy = 0;
  logic [7:0] mon_b;
  always @(negedge clk) begin
    if (!rst) mon_busy = 0;
    else if (!mon_busy) begin
      if (UART_out === 1'b0) begin
        mon_busy = 1;
        mon_t = 0;
      end
    end else begin
      mon_t++;
      if (mon_t >= 5 && mon_t <= 33 && (mon_t - 5) % 4 == 0) mon_b = {UART_out, mon_b[7:1]};
      if (mon_t == 37) begin
        chk("stop_bit", UART_out, 1);
        chk("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("tx_byte", mon_b, exp_q.pop_front());
        frames++;
        mon_busy = 0;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [39:0] s;
    logic [9:0] pat;
    int n, f0;
    bit low_seen;
    pat = {1'b1, 8'h48, 1'b0};
    push_banner();
    cyc(2);
    chk("reset_out", UART_out, 1);
    rst = 1'b1;
    cyc(1);
    chk("first_edge_idle", UART_out, 1);
    cyc(1);
    chk("second_edge_fall", UART_out, 0);
    s[0] = UART_out;
    for (int k = 1; k < 40; k++) begin
      cyc(1);
      s[k] = UART_out;
    end
    for (int i = 0; i < 10; i++) chk("bit_timing", s[i*4 +: 4], {4{pat[i]}});
    cyc(1);
    chk("stop_end_high", UART_out, 1);
    cyc(1);
    chk("next_start_gap", UART_out, 0);
    // two bytes during the banner: only the later one is echoed
    send(8'h31, 1'b1);
    exp_q.push_back(8'h32);
    send(8'h32, 1'b1);
    wait_empty(2000);
    low_seen = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (UART_out !== 1'b1) low_seen = 1;
    end
    chk("idle_high", low_seen, 0);
    exp_q.push_back(8'h41);
    send(8'h41, 1'b1);
    n = 40;
    while (UART_out !== 1'b0 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("echo_latency_ok", n >= 41 && n <= 44, 1);
    wait_empty(200);
    f0 = frames;
    UART_in = 1'b0;
    cyc(1);
    UART_in = 1'b1;
    cyc(60);
    chk("glitch_no_echo", frames, f0);
    send(8'hA5, 1'b0);
    cyc(60);
    chk("framing_no_echo", frames, f0);
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1);
    wait_empty(200);
    chk("echo_count", frames, f0 + 1);
    // restart the banner, then reset during its third byte
    rst = 1'b0;
    push_banner();
    cyc(2);
    rst = 1'b1;
    f0 = frames;
    n = 0;
    while (frames < f0 + 2 && n < 300) begin
      cyc(1);
      n++;
    end
    chk("two_frames_before_reset", frames, f0 + 2);
    n = 0;
    while (UART_out !== 1'b0 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("third_frame_started", UART_out, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_out", UART_out, 1);
    push_banner();
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("restart_idle", UART_out, 1);
    cyc(1);
    chk("restart_fall", UART_out, 0);
    f0 = frames;
    wait_empty(1000);
    chk("restart_frames", frames, f0 + 13);
    cyc(60);
    chk("final_idle", UART_out, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
